// File: rtl/serial_add_seq.sv
// Serial wide adder sequencer: drives an external 4-bit adder one nibble per cycle, LSB first.
// Optional signed-overflow flag is built when SERIAL_ADD_OVF_EN is defined.
module serial_add_seq #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  input  logic                   cin,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_cin,
  input  logic [3:0]             add_s,
  input  logic                   add_cout,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   cout,
  output logic                   ovf,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned W    = 4 * NIBBLES;
  localparam int unsigned IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      r_state,   w_nxt_state;
  logic [IDXW-1:0] r_idx,     w_nxt_idx;
  logic [W-1:0]    r_a,       w_nxt_a;
  logic [W-1:0]    r_b,       w_nxt_b;
  logic [W-1:0]    r_shadow,  w_nxt_shadow;
  logic [W-1:0]    r_result,  w_nxt_result;
  logic            r_cout,    w_nxt_cout;
  logic            r_busy,    w_nxt_busy;
  logic            r_done,    w_nxt_done;
  logic [3:0]      r_add_a,   w_nxt_add_a;
  logic [3:0]      r_add_b,   w_nxt_add_b;
  logic            r_add_cin, w_nxt_add_cin;
  logic [IDXW-1:0] w_idx_inc;

`ifdef SERIAL_ADD_OVF_EN
  logic            r_ovf,     w_nxt_ovf;
`endif

  assign w_idx_inc = r_idx + IDXW'(1);

  // Next-state and datapath; add_cin doubles as the running carry register
  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_idx     = r_idx;
    w_nxt_a       = r_a;
    w_nxt_b       = r_b;
    w_nxt_shadow  = r_shadow;
    w_nxt_result  = r_result;
    w_nxt_cout    = r_cout;
    w_nxt_busy    = r_busy;
    w_nxt_done    = r_done;
    w_nxt_add_a   = r_add_a;
    w_nxt_add_b   = r_add_b;
    w_nxt_add_cin = r_add_cin;
`ifdef SERIAL_ADD_OVF_EN
    w_nxt_ovf     = r_ovf;
`endif
    if (ena) begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_nxt_state   = S_RUN;
            w_nxt_a       = op_a;
            w_nxt_b       = op_b;
            w_nxt_idx     = '0;
            w_nxt_shadow  = '0;
            w_nxt_busy    = 1'b1;
            w_nxt_add_a   = op_a[3:0];
            w_nxt_add_b   = op_b[3:0];
            w_nxt_add_cin = cin;
          end
        end
        S_RUN: begin
          if (r_idx == LAST_IDX) begin
            // Top nibble goes straight from the adder into result
            w_nxt_state   = S_DONE;
            w_nxt_busy    = 1'b0;
            w_nxt_done    = 1'b1;
            w_nxt_result  = {add_s, r_shadow[W-5:0]};
            w_nxt_cout    = add_cout;
            w_nxt_add_a   = 4'h0;
            w_nxt_add_b   = 4'h0;
            w_nxt_add_cin = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            w_nxt_ovf     = (r_a[W-1] == r_b[W-1]) && (add_s[3] != r_a[W-1]);
`endif
          end else begin
            w_nxt_shadow[{r_idx, 2'b00} +: 4] = add_s;
            w_nxt_idx     = w_idx_inc;
            w_nxt_add_a   = r_a[{w_idx_inc, 2'b00} +: 4];
            w_nxt_add_b   = r_b[{w_idx_inc, 2'b00} +: 4];
            w_nxt_add_cin = add_cout;
          end
        end
        S_DONE: begin
          w_nxt_state = S_IDLE;
          w_nxt_done  = 1'b0;
        end
        default: begin
          w_nxt_state = S_IDLE;
          w_nxt_busy  = 1'b0;
          w_nxt_done  = 1'b0;
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_shadow  <= '0;
      r_result  <= '0;
      r_cout    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_add_a   <= 4'h0;
      r_add_b   <= 4'h0;
      r_add_cin <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      r_ovf     <= 1'b0;
`endif
    end else begin
      r_state   <= w_nxt_state;
      r_idx     <= w_nxt_idx;
      r_a       <= w_nxt_a;
      r_b       <= w_nxt_b;
      r_shadow  <= w_nxt_shadow;
      r_result  <= w_nxt_result;
      r_cout    <= w_nxt_cout;
      r_busy    <= w_nxt_busy;
      r_done    <= w_nxt_done;
      r_add_a   <= w_nxt_add_a;
      r_add_b   <= w_nxt_add_b;
      r_add_cin <= w_nxt_add_cin;
`ifdef SERIAL_ADD_OVF_EN
      r_ovf     <= w_nxt_ovf;
`endif
    end
  end

  assign add_a   = r_add_a;
  assign add_b   = r_add_b;
  assign add_cin = r_add_cin;
  assign result  = r_result;
  assign cout    = r_cout;
  assign busy    = r_busy;
  assign done    = r_done;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf     = r_ovf;
`else
  assign ovf     = 1'b0;
`endif

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed bench for serial_add_seq with NIBBLES=4 and a behavioural 4-bit adder.
module tb_serial_add_seq;

  localparam int unsigned NIB = 4;
  localparam int unsigned W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst_n, ena, start, cin_i;
  logic [W-1:0] op_a, op_b;
  logic [3:0]   add_a, add_b, add_s;
  logic         add_cin, add_cout;
  logic [W-1:0] result;
  logic         cout, ovf, busy, done;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_prev;

  always #5 clk = ~clk;

  // External combinational 4-bit adder stage
  assign {add_cout, add_s} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

  serial_add_seq #(.NIBBLES(NIB)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
    .op_a(op_a), .op_b(op_b), .cin(cin_i),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout),
    .result(result), .cout(cout), .ovf(ovf), .busy(busy), .done(done)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] res;
    logic         co;
    logic         ov;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic exp_ovf(input logic ov);
`ifdef SERIAL_ADD_OVF_EN
    return ov;
`else
    return 1'b0 & ov;
`endif
  endfunction

  task automatic run_op(input vec_t v);
    logic       carry;
    logic [4:0] tmp;
    @(negedge clk);
    op_a = v.a; op_b = v.b; cin_i = v.ci; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    carry = v.ci;
    for (int k = 0; k < NIB; k++) begin
      chk("run_busy", busy, 1);
      chk("run_done", done, 0);
      chk("run_hold", result, exp_prev);
      chk("run_add_a", add_a, v.a[4*k +: 4]);
      chk("run_add_b", add_b, v.b[4*k +: 4]);
      chk("run_add_cin", add_cin, carry);
      tmp   = 5'(v.a[4*k +: 4]) + 5'(v.b[4*k +: 4]) + 5'(carry);
      carry = tmp[4];
      @(posedge clk); #1;
    end
    chk("end_busy", busy, 0);
    chk("end_done", done, 1);
    chk("end_result", result, v.res);
    chk("end_cout", cout, v.co);
    chk("end_ovf", ovf, exp_ovf(v.ov));
    exp_prev = v.res;
    @(posedge clk); #1;
    chk("post_done", done, 0);
    chk("post_idle_add_a", add_a, 0);
    chk("post_result", result, v.res);
  endtask

  initial begin
    int   cnt;
    logic [3:0] hold_a;

    vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[3] = '{16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0};
    vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[7] = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0, 1'b0};

    rst_n = 1'b0; ena = 1'b1; start = 1'b0; cin_i = 1'b0;
    op_a = '0; op_b = '0; exp_prev = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_add", {add_a, add_b, add_cin}, 0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_op(vecs[i]);

    // start pulse during RUN must be ignored
    @(negedge clk);
    op_a = 16'h1234; op_b = 16'h0FFF; cin_i = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    op_a = 16'hAAAA; op_b = 16'h5555; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cnt = 2;
    while (!done && cnt < 30) begin @(posedge clk); #1; cnt++; end
    chk("ign_latency", cnt, NIB);
    chk("ign_result", result, 16'h2233);
    chk("ign_cout", cout, 0);
    exp_prev = 16'h2233;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk("ign_no_done", done, 0);
    end
    chk("ign_hold", result, 16'h2233);

    // asynchronous reset mid-RUN
    @(negedge clk);
    op_a = 16'h5555; op_b = 16'h1111; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_result", result, 0);
    chk("arst_add_a", add_a, 0);
    exp_prev = '0;
    @(negedge clk) rst_n = 1'b1;
    run_op(vecs[3]);

    // ena low for 3 cycles mid-RUN stretches latency by 3
    @(negedge clk);
    op_a = 16'hABCD; op_b = 16'h1234; cin_i = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    ena = 1'b0;
    hold_a = add_a;
    repeat (3) @(posedge clk);
    #1;
    chk("frz_add_a", add_a, hold_a);
    chk("frz_busy", busy, 1);
    chk("frz_done", done, 0);
    @(negedge clk) ena = 1'b1;
    cnt = 4;
    while (!done && cnt < 30) begin @(posedge clk); #1; cnt++; end
    chk("frz_latency", cnt, NIB + 3);
    chk("frz_result", result, 16'hBE01);
    chk("frz_cout", cout, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
